dcache_wb_2way: RTL

Two-way set-associative, write-back, write-allocate data cache placed between the CPU memory stage and main memory. It generalises the single-cycle-fill data cache: the set count and data width are parametrised, dirty victims are written back before eviction, and a stall/ready handshake covers multi-cycle main-memory latency. Hits complete with zero wait states. Misses stall the CPU while a small FSM performs an optional writeback followed by a refill.

---
 rtl/dcache_wb_2way.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/dcache_wb_2way.sv
// rtl/dcache_wb_2way.sv - two-way set-associative write-back write-allocate data cache
// Statistics counters are built only when DCACHE_STATS_EN is defined.
module dcache_wb_2way #(
  parameter int XLEN = 32,
  parameter int SETS = 512
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  input  logic            req_we,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic [XLEN-1:0] rdata,
  output logic            stall,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [31:0]     hit_cnt,
  output logic [31:0]     miss_cnt,
  output logic [31:0]     wb_cnt
);
  localparam int IDX = $clog2(SETS);
  localparam int TAG = XLEN - IDX - 2;

  typedef enum logic [1:0] {S_IDLE, S_WB, S_REFILL} state_t;
  state_t state_q;

  logic [SETS-1:0] valid0_q, valid1_q, dirty0_q, dirty1_q, lru_q;
  logic [TAG-1:0]  tag0_q  [SETS];
  logic [TAG-1:0]  tag1_q  [SETS];
  logic [XLEN-1:0] data0_q [SETS];
  logic [XLEN-1:0] data1_q [SETS];

  logic [IDX-1:0]  idx_q;
  logic [TAG-1:0]  tag_q;
  logic            victim_q;
  logic            mem_req_q, mem_we_q;
  logic [XLEN-1:0] mem_addr_q, mem_wdata_q;

  logic [IDX-1:0]  idx;
  logic [TAG-1:0]  tag;
  logic            hit0, hit1, hit, idle, acc_hit, miss;
  logic            victim_d, victim_dirty;
  logic [TAG-1:0]  victim_tag;
  logic [XLEN-1:0] victim_data;
  logic            wb_done, refill_done;
  logic            unused_addr_bits;

  assign idx  = req_addr[IDX+1:2];
  assign tag  = req_addr[XLEN-1:IDX+2];
  assign unused_addr_bits = ^req_addr[1:0];

  assign hit0    = valid0_q[idx] & (tag0_q[idx] == tag);
  assign hit1    = valid1_q[idx] & (tag1_q[idx] == tag);
  assign hit     = req_valid & (hit0 | hit1);
  assign idle    = (state_q == S_IDLE);
  assign acc_hit = idle & hit;
  assign miss    = idle & req_valid & ~hit;

  // An empty way is filled before anything is evicted; way0 first.
  assign victim_d     = ~valid0_q[idx] ? 1'b0 : (~valid1_q[idx] ? 1'b1 : lru_q[idx]);
  assign victim_dirty = victim_d ? (valid1_q[idx] & dirty1_q[idx])
                                 : (valid0_q[idx] & dirty0_q[idx]);
  assign victim_tag   = victim_d ? tag1_q[idx]  : tag0_q[idx];
  assign victim_data  = victim_d ? data1_q[idx] : data0_q[idx];

  assign wb_done     = (state_q == S_WB) & mem_ready;
  assign refill_done = (state_q == S_REFILL) & mem_ready;

  assign rdata = ~hit ? '0 : (hit0 ? data0_q[idx] : data1_q[idx]);
  assign stall = ~idle | (req_valid & ~hit);

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      valid0_q    <= '0;
      valid1_q    <= '0;
      dirty0_q    <= '0;
      dirty1_q    <= '0;
      lru_q       <= '0;
      idx_q       <= '0;
      tag_q       <= '0;
      victim_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (acc_hit) begin
            lru_q[idx] <= hit0;
            if (req_we) begin
              if (hit0) dirty0_q[idx] <= 1'b1;
              else      dirty1_q[idx] <= 1'b1;
            end
          end else if (miss) begin
            idx_q     <= idx;
            tag_q     <= tag;
            victim_q  <= victim_d;
            mem_req_q <= 1'b1;
            if (victim_dirty) begin
              state_q     <= S_WB;
              mem_we_q    <= 1'b1;
              mem_addr_q  <= {victim_tag, idx, 2'b00};
              mem_wdata_q <= victim_data;
            end else begin
              state_q     <= S_REFILL;
              mem_we_q    <= 1'b0;
              mem_addr_q  <= {tag, idx, 2'b00};
              mem_wdata_q <= '0;
            end
          end
        end
        S_WB: begin
          if (wb_done) begin
            state_q     <= S_REFILL;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {tag_q, idx_q, 2'b00};
            mem_wdata_q <= '0;
          end
        end
        S_REFILL: begin
          if (refill_done) begin
            state_q    <= S_IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            if (victim_q) begin
              valid1_q[idx_q] <= 1'b1;
              dirty1_q[idx_q] <= 1'b0;
            end else begin
              valid0_q[idx_q] <= 1'b1;
              dirty0_q[idx_q] <= 1'b0;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Tag and data storage carries no reset; the valid bits qualify it.
  always_ff @(posedge clk) begin
    if (rst_n && acc_hit && req_we) begin
      if (hit0) data0_q[idx] <= req_wdata;
      else      data1_q[idx] <= req_wdata;
    end else if (rst_n && refill_done) begin
      if (victim_q) begin
        tag1_q[idx_q]  <= tag_q;
        data1_q[idx_q] <= mem_rdata;
      end else begin
        tag0_q[idx_q]  <= tag_q;
        data0_q[idx_q] <= mem_rdata;
      end
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q, wb_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      if (acc_hit) hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss)    miss_cnt_q <= miss_cnt_q + 32'd1;
      if (wb_done) wb_cnt_q   <= wb_cnt_q + 32'd1;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
  assign wb_cnt   = wb_cnt_q;
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
  assign wb_cnt   = '0;
`endif

endmodule
